// File: rtl/req_gnt_pkg.sv
// Shared types and constants for the round-robin request/grant scheduler.
package req_gnt_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StGrant = 2'd2
  } state_e;

  localparam int unsigned DefNumReq   = 4;
  localparam int unsigned DefGntDelay = 4;
  localparam int unsigned DefHoldMax  = 8;

  localparam int unsigned DlyCntW  = 4;
  localparam int unsigned HoldCntW = 8;

  // Increment modulo n, used for the round-robin pointer.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/req_gnt_scheduler_if.sv
// Request/grant bundle between the requesting agents (master) and the scheduler (slave).
interface req_gnt_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
) ();

  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [IdW-1:0]     gnt_id;
  logic               busy;
  logic               timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     ptr,
  output logic [IdW-1:0]     idx,
  output logic               valid
);

  logic [IdW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IdW'((32'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/req_gnt_scheduler.sv
// Round-robin scheduler granting one shared resource GNT_DELAY cycles after acceptance.
// Define REQ_GNT_SCHED_ASSERT_EN to compile in protocol assertions.
module req_gnt_scheduler
  import req_gnt_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DefNumReq,
  parameter int unsigned GNT_DELAY = DefGntDelay,
  parameter int unsigned HOLD_MAX  = DefHoldMax,
  localparam int unsigned IdW      = $clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst,
  req_gnt_scheduler_if.slave bus
);

  state_e               state_q, state_d;
  logic [DlyCntW-1:0]   dly_cnt_q, dly_cnt_d;
  logic [HoldCntW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [IdW-1:0]       gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 timeout_q, timeout_d;

  logic [IdW-1:0]       pick_idx;
  logic                 pick_valid;

  // Arbitration always sees the live req levels; the pointer only moves on release.
  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    gnt_id_d   = gnt_id_q;
    gnt_d      = gnt_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_id_d = pick_idx;
          if (GNT_DELAY == 1) begin
            state_d    = StGrant;
            gnt_d      = NUM_REQ'(1) << pick_idx;
            hold_cnt_d = '0;
          end else begin
            state_d   = StWait;
            dly_cnt_d = DlyCntW'(GNT_DELAY - 1);
          end
        end
      end

      StWait: begin
        dly_cnt_d = dly_cnt_q - DlyCntW'(1);
        if (dly_cnt_q == DlyCntW'(1)) begin
          state_d    = StGrant;
          gnt_d      = NUM_REQ'(1) << gnt_id_q;
          hold_cnt_d = '0;
        end
      end

      StGrant: begin
        // done has priority, so a simultaneous hold expiry never raises timeout.
        if (bus.done || (hold_cnt_q == HoldCntW'(HOLD_MAX - 1))) begin
          state_d   = StIdle;
          gnt_d     = '0;
          ptr_d     = IdW'(wrap_inc(32'(gnt_id_q), NUM_REQ));
          timeout_d = !bus.done;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldCntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      dly_cnt_q  <= '0;
      hold_cnt_q <= '0;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      gnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      gnt_q      <= gnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.timeout = timeout_q;

`ifdef REQ_GNT_SCHED_ASSERT_EN
  logic accept;
  assign accept = (state_q == StIdle) && pick_valid;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q))
    $info("gnt onehot0 ok");
    else $error("gnt not onehot0: %b", gnt_q);

  a_gnt_delay: assert property (@(posedge clk) disable iff (rst)
      accept |-> ##GNT_DELAY gnt_q[gnt_id_q])
    $info("grant delay ok");
    else $error("grant not seen GNT_DELAY cycles after acceptance");

  a_hold_max: assert property (@(posedge clk) disable iff (rst)
      (state_q == StGrant) |-> (32'(hold_cnt_q) < HOLD_MAX))
    $info("tenure within HOLD_MAX");
    else $error("tenure exceeded HOLD_MAX");

  a_busy: assert property (@(posedge clk) disable iff (rst)
      bus.busy == (state_q != StIdle))
    $info("busy consistent");
    else $error("busy inconsistent with state");

  a_timeout_gnt: assert property (@(posedge clk) disable iff (rst)
      timeout_q |-> (gnt_q == '0))
    $info("timeout with gnt low");
    else $error("timeout while gnt high");
`endif

endmodule

// File: tb/tb_req_gnt_scheduler.sv
// Scoreboard bench: expected grants/tenures/timeouts queued at stimulus, checked by a monitor.
module tb_req_gnt_scheduler;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  req_gnt_scheduler_if #(.NUM_REQ(4)) bus0 ();
  req_gnt_scheduler_if #(.NUM_REQ(4)) bus1 ();

  req_gnt_scheduler #(
    .NUM_REQ   (4),
    .GNT_DELAY (4),
    .HOLD_MAX  (8)
  ) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  req_gnt_scheduler #(
    .NUM_REQ   (4),
    .GNT_DELAY (1),
    .HOLD_MAX  (1)
  ) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  typedef struct {
    logic [3:0] gnt;
    int         id;
    int         edge_n;
  } gexp_t;

  gexp_t exp_gnt[$];
  int    len_q[$];
  int    tmo_q[$];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge just before edge e.
  task automatic goto_edge(input int e);
    while (cyc + 1 < e) @(negedge clk);
  endtask

  task automatic push_gnt(input logic [3:0] g, input int id, input int e);
    gexp_t x;
    x.gnt    = g;
    x.id     = id;
    x.edge_n = e;
    exp_gnt.push_back(x);
  endtask

  // Monitor for dut0: values seen at a negedge are what the next posedge samples.
  initial begin
    logic [3:0] prev;
    int         run;
    gexp_t      e;
    prev = '0;
    run  = 0;
    forever begin
      @(negedge clk);
      if (bus0.gnt != '0) begin
        if (prev == '0) begin
          run = 0;
          if (exp_gnt.size() == 0) begin
            check("gnt_unexpected", bus0.gnt, 0);
          end else begin
            e = exp_gnt.pop_front();
            check("gnt_value", bus0.gnt, e.gnt);
            check("gnt_id", bus0.gnt_id, e.id);
            check("gnt_edge", cyc + 1, e.edge_n);
          end
        end
        run++;
      end else if (prev != '0 && len_q.size() != 0) begin
        check("tenure", run, len_q.pop_front());
      end
      if (bus0.timeout) begin
        check("timeout_gnt_low", bus0.gnt, 0);
        if (tmo_q.size() == 0) check("timeout_unexpected", bus0.timeout, 0);
        else check("timeout_edge", cyc + 1, tmo_q.pop_front());
      end
      prev = bus0.gnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.req  = '0;
    bus0.done = 1'b0;
    bus1.req  = '0;
    bus1.done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", bus0.gnt, 0);
    check("rst_gnt_id", bus0.gnt_id, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_timeout", bus0.timeout, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    // Single one-cycle request, released by done after three grant cycles.
    t = cyc + 1;
    bus0.req = 4'b0001;
    push_gnt(4'b0001, 0, t + 4);
    len_q.push_back(3);
    goto_edge(t + 1);
    bus0.req = '0;
    check("busy_after_accept", bus0.busy, 1);
    goto_edge(t + 6);
    bus0.done = 1'b1;
    goto_edge(t + 7);
    bus0.done = 1'b0;
    check("gnt_after_done", bus0.gnt, 0);
    check("busy_after_done", bus0.busy, 0);
    // Pointer is now 1, so requester 1 beats requester 0.
    bus0.req = 4'b0011;
    push_gnt(4'b0010, 1, t + 11);
    len_q.push_back(1);
    goto_edge(t + 8);
    bus0.req = '0;
    goto_edge(t + 11);
    bus0.done = 1'b1;
    goto_edge(t + 12);
    bus0.done = 1'b0;
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);

    // All requesting, done held: order 0,1,2,3,0 with a 5-cycle period.
    t = cyc + 1;
    bus0.req  = 4'b1111;
    bus0.done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_gnt(4'(1 << (k % 4)), k % 4, t + 4 + 5 * k);
      len_q.push_back(1);
    end
    goto_edge(t + 25);
    bus0.req  = '0;
    bus0.done = 1'b0;
    @(negedge clk);

    // Hold timeout, then immediate re-acceptance.
    t = cyc + 1;
    bus0.req = 4'b0100;
    push_gnt(4'b0100, 2, t + 4);
    len_q.push_back(8);
    tmo_q.push_back(t + 12);
    push_gnt(4'b0100, 2, t + 16);
    len_q.push_back(1);
    goto_edge(t + 16);
    bus0.done = 1'b1;
    goto_edge(t + 17);
    bus0.done = 1'b0;
    bus0.req  = '0;
    check("busy_idle_after_tmo", bus0.busy, 0);
    @(negedge clk);

    // Request dropped after acceptance is still granted.
    t = cyc + 1;
    bus0.req = 4'b0010;
    push_gnt(4'b0010, 1, t + 4);
    len_q.push_back(1);
    goto_edge(t + 1);
    bus0.req = '0;
    goto_edge(t + 4);
    bus0.done = 1'b1;
    goto_edge(t + 5);
    bus0.done = 1'b0;
    @(negedge clk);

    // Asynchronous reset during GRANT, pointer at 2 beforehand.
    t = cyc + 1;
    bus0.req = 4'b0010;
    push_gnt(4'b0010, 1, t + 4);
    goto_edge(t + 1);
    bus0.req = '0;
    goto_edge(t + 5);
    check("gnt_before_rst", bus0.gnt, 4'b0010);
    #2;
    rst0 = 1'b1;
    #1;
    check("rst_async_gnt", bus0.gnt, 0);
    check("rst_async_busy", bus0.busy, 0);
    check("rst_async_gnt_id", bus0.gnt_id, 0);
    check("rst_async_timeout", bus0.timeout, 0);
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    // Pointer back at 0: requester 0 wins over 3.
    t = cyc + 1;
    bus0.req = 4'b1001;
    push_gnt(4'b0001, 0, t + 4);
    len_q.push_back(1);
    goto_edge(t + 1);
    bus0.req = '0;
    goto_edge(t + 4);
    bus0.done = 1'b1;
    goto_edge(t + 5);
    bus0.done = 1'b0;
    bus0.req  = 4'b1000;
    push_gnt(4'b1000, 3, t + 9);
    len_q.push_back(1);
    goto_edge(t + 6);
    bus0.req = '0;
    goto_edge(t + 9);
    bus0.done = 1'b1;
    goto_edge(t + 10);
    bus0.done = 1'b0;
    @(negedge clk);

    // GNT_DELAY=1, HOLD_MAX=1 instance.
    t = cyc + 1;
    bus1.req = 4'b0001;
    check("d1_gnt_pre", bus1.gnt, 0);
    goto_edge(t + 1);
    check("d1_gnt_t1", bus1.gnt, 4'b0001);
    check("d1_busy_t1", bus1.busy, 1);
    check("d1_timeout_t1", bus1.timeout, 0);
    goto_edge(t + 2);
    check("d1_gnt_t2", bus1.gnt, 0);
    check("d1_timeout_t2", bus1.timeout, 1);
    check("d1_busy_t2", bus1.busy, 0);
    goto_edge(t + 3);
    check("d1_gnt_t3", bus1.gnt, 4'b0001);
    check("d1_gnt_id_t3", bus1.gnt_id, 0);
    check("d1_timeout_t3", bus1.timeout, 0);
    bus1.req = '0;
    goto_edge(t + 6);

    check("pending_gnts", exp_gnt.size(), 0);
    check("pending_tenures", len_q.size(), 0);
    check("pending_timeouts", tmo_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
